// File: rtl/seg_scan_driver_if.sv
// Bus between the value-producing logic and the seven-segment scan driver.
// The slave side is the driver; the master side loads codes and watches the pins.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [DIGITS-1:0]     blank_in;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, value_in, blank_in,
    input  seg, an, pending, frame_done
  );

  modport slave (
    input  load, value_in, blank_in,
    output seg, an, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with offset/range blanking and a
// double-buffered code store that only commits on frame boundaries.
module seg_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned OFFSET     = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
   localparam logic [3:0] OFF4 = 4'(OFFSET);
   localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW}};

   logic [PW-1:0]         pcnt_q;
   logic [IW-1:0]         idx_q;
   logic                  pending_q;
   logic [4*DIGITS-1:0]   shadow_val_q, active_val_q;
   logic [DIGITS-1:0]     shadow_blank_q, active_blank_q;
   logic [6:0]            seg_q;
   logic [DIGITS-1:0]     an_q;

   logic                  tick, last_idx, boundary;
   logic [3:0]            cur_code;
   logic                  cur_blank;
   logic [6:0]            glyph;
   logic [DIGITS-1:0]     onehot;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] g;
      unique case (v)
         4'h0: g = 7'h3f;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5b;
         4'h3: g = 7'h4f;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6d;
         4'h6: g = 7'h7d;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7f;
         4'h9: g = 7'h6f;
         4'ha: g = 7'h77;
         4'hb: g = 7'h7c;
         4'hc: g = 7'h39;
         4'hd: g = 7'h5e;
         4'he: g = 7'h79;
         4'hf: g = 7'h71;
      endcase
      return g;
   endfunction

   always_comb begin
      tick      = (pcnt_q == PMAX);
      last_idx  = (idx_q == IMAX);
      boundary  = tick && last_idx;
      cur_code  = active_val_q[{idx_q, 2'b00} +: 4];
      cur_blank = active_blank_q[idx_q];
      // codes below the offset have no glyph, so they are shown blank
      if (cur_blank || (cur_code < OFF4)) begin
         glyph = 7'h00;
      end else begin
         glyph = hex7(cur_code - OFF4);
      end
      onehot        = '0;
      onehot[idx_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q         <= '0;
         idx_q          <= '0;
         pending_q      <= 1'b0;
         shadow_val_q   <= '0;
         shadow_blank_q <= '1;
         active_val_q   <= '0;
         active_blank_q <= '1;
         seg_q          <= SEG_OFF;
         an_q           <= AN_OFF;
      end else begin
         pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
         if (tick) begin
            idx_q <= last_idx ? '0 : idx_q + 1'b1;
         end
         // active takes the shadow as it was before any coincident load
         if (boundary && pending_q) begin
            active_val_q   <= shadow_val_q;
            active_blank_q <= shadow_blank_q;
         end
         if (bus.load) begin
            shadow_val_q   <= bus.value_in;
            shadow_blank_q <= bus.blank_in;
            pending_q      <= 1'b1;
         end else if (boundary) begin
            pending_q <= 1'b0;
         end
         seg_q <= glyph ^ SEG_OFF;
         an_q  <= onehot ^ AN_OFF;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes expected per-frame glyphs keyed by frame number,
// a monitor assembles each displayed frame from the pins and compares.
module tb_seg_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_driver_if #(.DIGITS(4)) b1 ();
   seg_scan_driver_if #(.DIGITS(4)) b2 ();

   seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .OFFSET(2), .ACTIVE_LOW(1'b0)) dut (
     .clk (clk),
     .rst (rst),
     .bus (b1)
   );

   seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .OFFSET(2), .ACTIVE_LOW(1'b1)) dut_al (
     .clk (clk),
     .rst (rst),
     .bus (b2)
   );

   typedef struct {
      int          id;
      logic [27:0] g;   // digit d glyph at [7d +: 7]
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   nframes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame number = count of commit boundaries seen so far
   always @(posedge clk) begin
      if (b1.frame_done === 1'b1) nframes <= nframes + 1;
   end

   // Monitor
   int          cur_id = 0;
   logic [27:0] cap = '0;
   logic [3:0]  seen = '0;
   logic [3:0]  an_prev = '0;

   task automatic finalize();
      exp_t e;
      while (q.size() > 0 && q[0].id < cur_id) begin
         e = q.pop_front();
         tests++;
         fails++;
         $display("FAIL frame_missed: frame %0d never checked, now at frame %0d", e.id, cur_id);
      end
      if (q.size() > 0 && q[0].id == cur_id) begin
         e = q.pop_front();
         chk($sformatf("frame%0d_glyphs", e.id), {4'b0, cap}, {4'b0, e.g});
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         seen = '0;
      end else begin
         if (b1.an == 4'b0001 && an_prev != 4'b0001) begin
            if (seen == 4'hf) finalize();
            cur_id = nframes;
            seen   = '0;
         end
         case (b1.an)
            4'b0001: begin cap[6:0]   = b1.seg; seen[0] = 1'b1; end
            4'b0010: begin cap[13:7]  = b1.seg; seen[1] = 1'b1; end
            4'b0100: begin cap[20:14] = b1.seg; seen[2] = 1'b1; end
            4'b1000: begin cap[27:21] = b1.seg; seen[3] = 1'b1; end
            default: ;
         endcase
      end
      an_prev = b1.an;
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] b);
      b1.load     = 1'b1;
      b1.value_in = v;
      b1.blank_in = b;
      @(negedge clk);
      b1.load = 1'b0;
   endtask

   task automatic wait_fd();
      int n = 0;
      @(negedge clk);
      while (b1.frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (b1.frame_done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL frame_done_timeout: got 0, expected a pulse within 100 cycles");
      end
   endtask

   task automatic wait_an2(input logic [3:0] want);
      int n = 0;
      while (b2.an !== want && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("al_an_reached", {28'b0, b2.an}, {28'b0, want});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      b1.load = 1'b0; b1.value_in = '0; b1.blank_in = '0;
      b2.load = 1'b0; b2.value_in = '0; b2.blank_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg", {25'b0, b1.seg}, 32'h00);
      chk("rst_an", {28'b0, b1.an}, 32'h0);
      chk("rst_pending", {31'b0, b1.pending}, 32'h0);
      chk("rst_frame_done", {31'b0, b1.frame_done}, 32'h0);
      chk("rst_seg_al", {25'b0, b2.seg}, 32'h7f);
      chk("rst_an_al", {28'b0, b2.an}, 32'hf);
      q.push_back('{0, 28'h0});
      q.push_back('{1, 28'h0});

      rst = 1'b0;
      // digit1 code A -> glyph 8 on the active-low instance, other digits blanked
      b2.load = 1'b1; b2.value_in = 16'h00a0; b2.blank_in = 4'b1101;
      for (int i = 1; i <= 16; i++) begin
         logic [3:0] e_an;
         @(negedge clk);
         b2.load = 1'b0;
         e_an = 4'(1 << ((i - 1) / 4));
         chk("an_rotate", {28'b0, b1.an}, {28'b0, e_an});
         chk("frame_done_pulse", {31'b0, b1.frame_done}, (i == 15) ? 32'h1 : 32'h0);
         if (i == 1) chk("seg_blank_first", {25'b0, b1.seg}, 32'h00);
      end

      // mid-frame load in frame 1 commits for frame 2: codes 2,3,4,7 -> 0,1,2,5
      repeat (2) @(negedge clk);
      q.push_back('{nframes + 1, {7'h6d, 7'h5b, 7'h06, 7'h3f}});
      do_load(16'h7432, 4'b0000);
      chk("pending_set", {31'b0, b1.pending}, 32'h1);

      // range: 0 and 1 below offset, F -> D
      wait_fd();
      repeat (2) @(negedge clk);
      chk("pending_cleared", {31'b0, b1.pending}, 32'h0);
      q.push_back('{nframes + 1, {7'h00, 7'h5e, 7'h00, 7'h00}});
      do_load(16'h1f10, 4'b0000);

      // two loads in one frame: second wins, digit2 force-blanked
      wait_fd();
      repeat (2) @(negedge clk);
      do_load(16'h7432, 4'b0000);
      repeat (2) @(negedge clk);
      q.push_back('{nframes + 1, {7'h4f, 7'h00, 7'h4f, 7'h4f}});
      do_load(16'h5555, 4'b0100);

      // load on the boundary cycle: old shadow commits, new one a frame later
      wait_fd();
      repeat (2) @(negedge clk);
      do_load(16'hba98, 4'b0000);
      wait_fd();
      nf = nframes;
      q.push_back('{nf + 1, {7'h6f, 7'h7f, 7'h07, 7'h7d}});
      q.push_back('{nf + 2, {7'h06, 7'h77, 7'h3f, 7'h39}});
      do_load(16'h3c2e, 4'b0000);
      chk("pending_hold_on_boundary", {31'b0, b1.pending}, 32'h1);

      // active-low polarity on the second instance
      wait_an2(4'b1101);
      chk("al_seg_digit1", {25'b0, b2.seg}, 32'h00);
      wait_an2(4'b1110);
      chk("al_seg_digit0", {25'b0, b2.seg}, 32'h7f);

      wait_drain();

      // async reset mid-frame with data pending
      repeat (3) @(negedge clk);
      do_load(16'h1234, 4'b0000);
      chk("pending_before_rst", {31'b0, b1.pending}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_seg", {25'b0, b1.seg}, 32'h00);
      chk("async_rst_an", {28'b0, b1.an}, 32'h0);
      chk("async_rst_pending", {31'b0, b1.pending}, 32'h0);
      chk("async_rst_an_al", {28'b0, b2.an}, 32'hf);
      @(negedge clk);
      rst = 1'b0;
      q.push_back('{nframes, 28'h0});
      q.push_back('{nframes + 1, 28'h0});
      wait_drain();

      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         tests++;
         fails++;
         $display("FAIL frame_unchecked: frame %0d got no display, expected %0h", e.id, e.g);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
